// File: rtl/ysyx_25020042_lsu.sv
// Multi-cycle load/store unit: IDLE -> ACCESS (MEM_LAT cycles) -> RESP, one response per request.
// Optional misaligned-access trap enabled by defining YSYX_25020042_LSU_MISALIGN_CHECK_EN.
module ysyx_25020042_lsu #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [WIDTH-1:0]    req_wdata,
    output logic                resp_valid,
    output logic [WIDTH-1:0]    resp_rdata,
    output logic                resp_err,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic [3:0]          mem_byte_en,
    output logic                mem_we,
    input  logic [WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic                  wen_q;
    logic [2:0]            funct3_q;
    logic [ADDR_LEN-1:0]   addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      rdata_q;
    logic                  err_q;

    logic                  legal;
    logic                  misalign;
    logic                  access_ok;
    logic                  first_cycle;
    logic [3:0]            be_raw;
    logic [WIDTH-1:0]      wdata_rep;
    logic [WIDTH-1:0]      load_val;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    // Request decode, lane steering and load extraction, all from the latched request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        legal     = 1'b0;
        misalign  = 1'b0;
        be_raw    = 4'b0000;
        wdata_rep = wdata_q;
        load_val  = '0;
        byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = mem_rdata[{addr_q[1], 4'b0000} +: 16];

        if (wen_q) legal = funct3_q inside {3'd0, 3'd1, 3'd2};
        else       legal = funct3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        case (funct3_q[1:0])
            2'd0: begin
                be_raw    = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be_raw    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: be_raw = 4'b1111;
        endcase

`ifdef YSYX_25020042_LSU_MISALIGN_CHECK_EN
        misalign = (funct3_q[1:0] == 2'd1 && addr_q[0]) ||
                   (funct3_q[1:0] == 2'd2 && addr_q[1:0] != 2'b00);
`endif

        case (funct3_q)
            3'd0:    load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{(WIDTH-16){half_sel[15]}}, half_sel};
            3'd2:    load_val = mem_rdata;
            3'd4:    load_val = {{(WIDTH-8){1'b0}}, byte_sel};
            3'd5:    load_val = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_val = '0;
        endcase
        if (wen_q || !legal || misalign) load_val = '0;
    end

    assign access_ok   = legal && !misalign;
    assign first_cycle = (cnt == 4'(MEM_LAT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: all registers here are plain flops (no memory array), so each is cleared on reset.
            state    <= IDLE;
            cnt      <= 4'd0;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    wen_q    <= req_wen;
                    funct3_q <= req_funct3;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    cnt      <= 4'(MEM_LAT - 1);
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata_q <= load_val;
                        err_q   <= legal && misalign;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM-side signals are only driven while an access is in flight.
    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign mem_addr    = (state == ACCESS) ? {addr_q[ADDR_LEN-1:2], 2'b00} : '0;
    assign mem_wdata   = (state == ACCESS) ? wdata_rep : '0;
    assign mem_byte_en = (state == ACCESS && access_ok) ? be_raw : 4'b0000;
    assign mem_we      = (state == ACCESS) && wen_q && access_ok && first_cycle;

endmodule
